// File: rtl/multi_dice_roller_pkg.sv
// multi_dice_roller_pkg: shared constants for the dice roller
//   package dice_pkg
//   - state_e / ST_*  : roller FSM states (IDLE, ROLLING)
//   - PIP_PATTERN     : 3x3 pip grid per face 1..9, row-major, bit0 top-left
//   - LFSR_W/LFSR_TAPS: 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1
//   - DEFAULT_SEED    : fallback seed when a zero seed is configured
package dice_pkg;

    typedef enum logic [0:0] {IDLE = 1'b0, ROLLING = 1'b1} state_e;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_ROLLING = 1'b1;

    localparam logic [8:0] PIP_PATTERN [1:9] = '{
        9'h010, 9'h101, 9'h111, 9'h145, 9'h155,
        9'h16D, 9'h17D, 9'h1EF, 9'h1FF
    };

    localparam int          LFSR_W       = 16;
    // Tap mask for a left-shifting register: bits 15,13,12,10 = taps 16,14,13,11
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/multi_dice_roller_if.sv
// multi_dice_roller_if: roll request / result bundle of the dice roller
//   roll  : request, driven by the master
//   busy  : rolling phase in progress
//   done  : one-cycle pulse when a roll finishes
//   value : per-die face minus 1, die k at [4k+3:4k]
//   seg   : per-die pip pattern, die k at [9k+8:9k]
interface multi_dice_roller_if #(
    parameter int NUM_DICE = 2
);
    logic                    roll;
    logic                    busy;
    logic                    done;
    logic [NUM_DICE*4-1:0]   value;
    logic [NUM_DICE*9-1:0]   seg;

    modport master (output roll, input busy, done, value, seg);
    modport slave  (input roll, output busy, done, value, seg);
endinterface

// File: rtl/multi_dice_roller_pip_decoder.sv
// dice_pip_decoder: combinational face (1..9) to 3x3 pip pattern
//   face    : 4-bit face number; anything outside 1..9 yields a blank grid
//   pattern : 9-bit row-major pip pattern
module dice_pip_decoder
    import dice_pkg::*;
(
    input  logic [3:0] face,
    output logic [8:0] pattern
);
    assign pattern = (face >= 4'd1 && face <= 4'd9) ? PIP_PATTERN[face] : 9'h000;
endmodule

// File: rtl/multi_dice_roller.sv
// multi_dice_roller: N-die pseudo-random roller driving 3x3 pip displays
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : multi_dice_roller_if slave (roll in; busy, done, value, seg out)
// Build option: define DICE_ROLL_ANIM_EN to let seg animate while rolling;
// otherwise seg is blank for the whole roll and shows only the final faces.
module multi_dice_roller
    import dice_pkg::*;
#(
    parameter int          NUM_DICE    = 2,
    parameter int          FACES       = 8,
    parameter int          ROLL_CYCLES = 16,
    parameter logic [15:0] LFSR_SEED   = DEFAULT_SEED
) (
    input logic                clk,
    input logic                rst,
    multi_dice_roller_if.slave bus
);
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? DEFAULT_SEED : LFSR_SEED;
    localparam int          CW   = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;

    logic [0:0]        state, state_nx;
    logic [CW-1:0]     cnt;
    logic [LFSR_W-1:0] lfsr;
    logic              done;
    logic              last;
    logic              blank;

    assign last = cnt == CW'(ROLL_CYCLES - 1);

    always_comb
        state_nx = (state == ST_IDLE) ? (bus.roll ? ST_ROLLING : ST_IDLE)
                                      : (last ? ST_IDLE : ST_ROLLING);

    // The LFSR free-runs in every state so the moment a roll is requested
    // contributes to the outcome.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            lfsr  <= SEED;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (state == ST_IDLE) ? '0 : cnt + 1'b1;
            lfsr  <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
            done  <= (state == ST_ROLLING) && last;
        end
    end

`ifdef DICE_ROLL_ANIM_EN
    assign blank = 1'b0;
`else
    // Blank while rolling and through the done cycle, since the registered
    // pattern only catches up with the final value one cycle later.
    assign blank = (state == ST_ROLLING) || (state_nx == ST_ROLLING);
`endif

    assign bus.busy = state == ST_ROLLING;
    assign bus.done = done;

    for (genvar k = 0; k < NUM_DICE; k++) begin : g_die
        logic [3:0] val;
        logic [8:0] pip;
        logic [8:0] seg_r;

        always_ff @(posedge clk) begin
            if (rst)
                val <= 4'd0;
            else if (state == ST_ROLLING && lfsr[k])
                val <= (val == 4'(FACES - 1)) ? 4'd0 : val + 4'd1;
        end

        dice_pip_decoder u_dec (
            .face    (val + 4'd1),
            .pattern (pip)
        );

        always_ff @(posedge clk) begin
            if (rst)
                seg_r <= PIP_PATTERN[1];
            else
                seg_r <= blank ? 9'h000 : pip;
        end

        assign bus.value[4*k +: 4] = val;
        assign bus.seg[9*k +: 9]   = seg_r;
    end
endmodule

// File: tb/tb_multi_dice_roller.sv
// tb_multi_dice_roller: self-checking bench for multi_dice_roller and dice_pip_decoder
module tb_multi_dice_roller;
    localparam int          ND   = 4;
    localparam int          FC   = 6;
    localparam int          RC   = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_dice_roller_if #(.NUM_DICE(ND)) bus ();

    multi_dice_roller #(
        .NUM_DICE    (ND),
        .FACES       (FC),
        .ROLL_CYCLES (RC),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [3:0] dec_face;
    logic [8:0] dec_pat;
    dice_pip_decoder u_dec (.face(dec_face), .pattern(dec_pat));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] pat(input int f);
        case (f)
            1: return 9'h010;
            2: return 9'h101;
            3: return 9'h111;
            4: return 9'h145;
            5: return 9'h155;
            6: return 9'h16D;
            7: return 9'h17D;
            8: return 9'h1EF;
            9: return 9'h1FF;
            default: return 9'h000;
        endcase
    endfunction

    function automatic logic [15:0] nxt(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Reference model: busy/done timeline plus a scoreboard of final values,
    // computed at acceptance by looking the LFSR ahead over the roll.
    logic [15:0] m_lfsr = SEED;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    int          m_val [ND] = '{default: 0};
    logic [ND*4-1:0] sb_q [$];

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
            m_val  = '{default: 0};
            sb_q.delete();
            m_lfsr = SEED;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (bus.roll) begin
                logic [15:0]     l;
                logic [ND*4-1:0] e;
                m_busy = 1'b1;
                m_left = RC;
                l = m_lfsr;
                for (int i = 0; i < RC; i++) begin
                    l = nxt(l);
                    for (int k = 0; k < ND; k++)
                        if (l[k]) m_val[k] = (m_val[k] + 1) % FC;
                end
                for (int k = 0; k < ND; k++) e[4*k +: 4] = 4'(m_val[k]);
                sb_q.push_back(e);
            end
            m_lfsr = nxt(m_lfsr);
        end
    end

    logic            checking = 1'b0;
    logic [ND*4-1:0] prev_val = '0;
    logic [ND*9-1:0] prev_seg = '0;
    int              wraps = 0;
    int              anim_changes = 0;

    always @(negedge clk) begin
        if (checking) begin
            chk("busy", bus.busy, m_busy);
            chk("done", bus.done, m_done);
            for (int k = 0; k < ND; k++) begin
                chk("value_range", bus.value[4*k +: 4] < 4'(FC), 1'b1);
                if (prev_val[4*k +: 4] == 4'(FC - 1) && bus.value[4*k +: 4] == 4'd0) wraps++;
                if (!m_busy && !m_done)
                    chk("seg_idle", bus.seg[9*k +: 9], pat(m_val[k] + 1));
`ifndef DICE_ROLL_ANIM_EN
                else
                    chk("seg_blank", bus.seg[9*k +: 9], 9'h000);
`endif
            end
            if (m_busy && bus.seg != prev_seg) anim_changes++;
            if (m_done) begin
                if (sb_q.size() == 0) chk("scoreboard_empty", 1'b1, 1'b0);
                else chk("value_final", bus.value, sb_q.pop_front());
            end
        end
        prev_val = bus.value;
        prev_seg = bus.seg;
    end

    typedef struct {
        logic [3:0] face;
        logic [8:0] exp;
    } dvec_t;
    dvec_t dtab [16];

    task automatic reset_outputs_check(input string tag);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_done"}, bus.done, 1'b0);
        chk({tag, "_value"}, bus.value, '0);
        for (int k = 0; k < ND; k++) chk({tag, "_seg"}, bus.seg[9*k +: 9], 9'h010);
    endtask

    initial begin
        int dn;
        for (int i = 0; i < 16; i++) dtab[i] = '{face: 4'(i), exp: pat(i)};
        bus.roll = 1'b0;
        dec_face = 4'd0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        reset_outputs_check("reset");
        checking = 1'b1;

        for (int i = 0; i < 16; i++) begin
            dec_face = dtab[i].face;
            #1;
            chk($sformatf("decoder_face%0d", i), dec_pat, dtab[i].exp);
        end

        // single roll
        @(negedge clk);
        bus.roll = 1'b1;
        @(negedge clk);
        bus.roll = 1'b0;
        repeat (7) @(negedge clk);

        // busy lockout: second request during the roll
        bus.roll = 1'b1;
        @(negedge clk);
        bus.roll = 1'b0;
        @(negedge clk);
        bus.roll = 1'b1;
        @(negedge clk);
        bus.roll = 1'b0;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) dn++;
            @(negedge clk);
        end
        chk("lockout_done_count", dn, 1);

        // abort mid-roll
        bus.roll = 1'b1;
        @(negedge clk);
        bus.roll = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        reset_outputs_check("abort");
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // reset and roll together
        rst = 1'b1;
        bus.roll = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.roll = 1'b0;
        chk("rst_wins_busy", bus.busy, 1'b0);
        repeat (2) @(negedge clk);

        // held roll: back-to-back rolls and wraps
        bus.roll = 1'b1;
        repeat (200) @(negedge clk);
        bus.roll = 1'b0;
        repeat (8) @(negedge clk);

        chk("wraps_seen", wraps > 0, 1'b1);
        chk("scoreboard_drained", sb_q.size(), 0);
`ifdef DICE_ROLL_ANIM_EN
        chk("anim_changes", anim_changes > 0, 1'b1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_dice_roller.md
# multi_dice_roller

Parametrised N-die roller for the nine-segment (3x3 pip grid) LED display. A roll request starts a fixed-length rolling phase in which each die's face is stepped pseudo-randomly from a free-running LFSR. The dice then freeze, a one-cycle `done` pulse is issued, and each die's registered pip pattern is presented to the display. It replaces the single combinational 3-bit-to-pip decoder as the top-level dice source.

## Interface
Parameters:
- `NUM_DICE`, 2: number of dice; legal 1..16.
- `FACES`, 8: faces per die; legal 2..9; faces shown 1..FACES.
- `ROLL_CYCLES`, 16: length of the rolling phase in clocks; legal >= 1.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero (0 is replaced by 16'hACE1).

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `roll`, in, 1: roll request; level-sampled, acted on only when `busy`=0.
- `busy`, out, 1: high during the rolling phase.
- `done`, out, 1: one-cycle pulse after a roll completes.
- `value`, out, NUM_DICE*4: per-die face minus 1 (0..FACES-1); die k at [4k+3:4k].
- `seg`, out, NUM_DICE*9: per-die pip pattern; die k at [9k+8:9k].

## Operation
- LFSR: 16-bit Fibonacci, taps 16,14,13,11 (x^16+x^14+x^13+x^11+1), shifts every cycle regardless of state. Roll timing therefore adds entropy.
- States: IDLE, ROLLING.
  - IDLE with `roll`=1 -> ROLLING; cycle counter cleared.
  - ROLLING: counter increments. When counter = ROLL_CYCLES-1, go to IDLE and assert `done` next cycle.
- In ROLLING, die k increments `value` by 1 on each cycle where lfsr[k]=1. It wraps from FACES-1 to 0 and holds otherwise. In IDLE, values hold.
- Pip grid bits are row-major: bit0 top-left, bit4 centre, bit8 bottom-right. Faces 1..9 map to 0x010, 0x101, 0x111, 0x145, 0x155, 0x16D, 0x17D, 0x1EF, 0x1FF.
- `roll` while `busy`=1 is ignored; there is no queuing.
- `roll` held high re-rolls back-to-back. The new roll is accepted in the `done` cycle.

## Timing
- Reset values:
  - `busy`=0, `done`=0.
  - every `value` lane = 0; every `seg` lane = 0x010.
  - LFSR = LFSR_SEED; state IDLE.
- `roll` sampled high at edge T: `busy`=1 from T+1 through T+ROLL_CYCLES.
- At T+ROLL_CYCLES+1: `busy`=0, `done`=1 for exactly one cycle, and `value` is final.
- `seg` is registered: it reflects `value` with one cycle of latency, so it is final at T+ROLL_CYCLES+2.
- `rst` mid-roll aborts the roll immediately with no `done` pulse; all outputs return to reset values.
- Simultaneous `rst` and `roll`: reset wins.

## Configuration
- `DICE_ROLL_ANIM_EN` defined: `seg` tracks the stepping values during ROLLING, giving a visible animation.
- `DICE_ROLL_ANIM_EN` undefined: `seg` is 0 (blank) in every lane while `busy`=1. It shows the final pattern from T+ROLL_CYCLES+2.
- `value` behaviour is identical in both builds.

## Structure
- Package `dice_pkg` contains:
  - state enum (IDLE, ROLLING)
  - `PIP_PATTERN[1:9]` constant array of 9-bit patterns
  - LFSR width and tap constants
  - default seed
- Sub-module `dice_pip_decoder`: combinational, face (4-bit, 1..9) -> 9-bit pattern. Out-of-range input gives 0. It is instantiated once per die.

## Test plan
- Reset check: assert `rst` for 2 cycles, then release -> `busy`=0, `done`=0, `value`=0, every `seg` lane 0x010, state IDLE.
- Roll length: ROLL_CYCLES=4, one-cycle `roll` at edge T -> `busy` high for T+1..T+4; `done`=1 only at T+5. Final `value` matches a bench LFSR model seeded with 16'hACE1.
- Busy lockout: pulse `roll` at T+2 during a roll -> no extra busy cycles and exactly one `done` pulse.
- Wrap: FACES=6, NUM_DICE=4, `roll` held high for 200 cycles -> every lane stays in 0..5 throughout, wraps 5->0 occur, and a `done` pulse comes every ROLL_CYCLES+1 cycles.
- Decoder: drive `dice_pip_decoder` with faces 0..15 -> 1..9 give the listed patterns; 0 and 10..15 give 0.
- Abort and macro:
  - assert `rst` at T+2 of a roll -> outputs at reset values next cycle, and no `done`.
  - with `DICE_ROLL_ANIM_EN` undefined, `seg`=0 throughout `busy`.
  - with `DICE_ROLL_ANIM_EN` defined, `seg` changes during `busy`.
